irq_arbiter32: RTL and testbench

IRQ_ARBITER32 -- requirements
Module: irq_arbiter32

---
 rtl/irq_arbiter32_pkg.sv | 30 +++
 rtl/rr_onehot_pick32.sv | 30 +++
 rtl/irq_arbiter32.sv | 91 +++++++++
 tb/tb_irq_arbiter32.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_arbiter32_pkg.sv
// Shared definitions for the 32-line round-robin interrupt arbiter:
// FSM state encoding, sizing constants and a one-hot to index helper.
package irq_arbiter32_pkg;

  localparam int NUM_REQ = 32;
  localparam int ID_W    = 5;

  // After reset the search starts at index 0, so the "last granted" index
  // is parked on the highest line.
  localparam logic [ID_W-1:0] LAST_ID_RESET = 5'd31;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    GRANT  = 2'd2
  } arbState_t;

  // Converts a one-hot vector to its binary index; an all-zero vector maps to 0.
  function automatic logic [ID_W-1:0] oneHotToIndex(input logic [NUM_REQ-1:0] oneHot);
    logic [ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oneHot[i]) begin
        idx = idx | ID_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_onehot_pick32.sv
// Combinational round-robin picker: returns the first set bit of reqVec
// found when searching upward from lastId+1, wrapping from 31 to 0.
module rr_onehot_pick32
  import irq_arbiter32_pkg::*;
(
  input  logic [NUM_REQ-1:0] reqVec,
  input  logic [ID_W-1:0]    lastId,
  output logic [NUM_REQ-1:0] winner,
  output logic               none
);

  logic [ID_W-1:0] probeIdx;
  logic            found;

  // Walk the 32 positions in priority order and latch the first hit.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    probeIdx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probeIdx = lastId + 5'd1 + ID_W'(k);
      if (!found && reqVec[probeIdx]) begin
        winner[probeIdx] = 1'b1;
        found            = 1'b1;
      end
    end
    none = !found;
  end

endmodule

// File: rtl/irq_arbiter32.sv
// Edge-triggered interrupt arbiter: rising edges on reqIn become pending
// bits, and enabled pending bits are granted one at a time in round-robin
// order through an IDLE -> SELECT -> GRANT handshake.
module irq_arbiter32 #(
  parameter int NUM_REQ = 32,
  parameter int ID_W    = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] reqIn,
  input  logic [NUM_REQ-1:0] maskIn,
  input  logic               grantAck,
  output logic               grantValid,
  output logic [ID_W-1:0]    grantId,
  output logic [NUM_REQ-1:0] grantOneHot,
  output logic [NUM_REQ-1:0] pendingOut
);
  import irq_arbiter32_pkg::*;

  arbState_t          state;
  arbState_t          nextState;
  logic [NUM_REQ-1:0] prevReq;
  logic [NUM_REQ-1:0] pending;
  logic [NUM_REQ-1:0] nextPending;
  logic [NUM_REQ-1:0] risingEdge;
  logic [NUM_REQ-1:0] ackClear;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] winner;
  logic [ID_W-1:0]    lastId;
  logic               noneEligible;
  logic               ackNow;

  assign risingEdge = reqIn & ~prevReq;
  assign eligible   = pending & maskIn;
  assign ackNow     = (state == GRANT) && grantAck;
  assign grantValid = (state == GRANT);
  assign pendingOut = pending;

  rr_onehot_pick32 picker (
    .reqVec (eligible),
    .lastId (lastId),
    .winner (winner),
    .none   (noneEligible)
  );

  // Acknowledge clears the granted bit, but a fresh edge on the same line wins.
  always_comb begin
    ackClear    = ackNow ? grantOneHot : '0;
    nextPending = (pending & ~ackClear) | risingEdge;
  end

  // Next-state logic; SELECT falls back to IDLE if the enabled set emptied meanwhile.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (|eligible) nextState = SELECT;
      SELECT:  nextState = noneEligible ? IDLE : GRANT;
      GRANT:   if (grantAck) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // State, edge-detect history and pending requests.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      prevReq <= '0;
      pending <= '0;
    end else begin
      state   <= nextState;
      prevReq <= reqIn;
      pending <= nextPending;
    end
  end

  // Grant registers are captured in SELECT and held untouched until acknowledged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grantId     <= '0;
      grantOneHot <= '0;
      lastId      <= LAST_ID_RESET;
    end else if (state == SELECT && !noneEligible) begin
      grantOneHot <= winner;
      grantId     <= oneHotToIndex(winner);
    end else if (ackNow) begin
      grantOneHot <= '0;
      lastId      <= grantId;
    end
  end

endmodule

// File: tb/tb_irq_arbiter32.sv
// Self-checking bench for irq_arbiter32: expected grant indices are queued
// when request edges are driven and compared when the grant appears.
module tb_irq_arbiter32;

  logic        clk;
  logic        reset;
  logic [31:0] reqIn;
  logic [31:0] maskIn;
  logic        grantAck;
  logic        grantValid;
  logic [4:0]  grantId;
  logic [31:0] grantOneHot;
  logic [31:0] pendingOut;

  int errorCount = 0;
  int checkCount = 0;
  int expIds[$];

  irq_arbiter32 dut (
    .clk         (clk),
    .reset       (reset),
    .reqIn       (reqIn),
    .maskIn      (maskIn),
    .grantAck    (grantAck),
    .grantValid  (grantValid),
    .grantId     (grantId),
    .grantOneHot (grantOneHot),
    .pendingOut  (pendingOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] req, input logic [31:0] mask);
    reqIn  = req;
    maskIn = mask;
  endtask

  // Waits (bounded) for a grant, then pops the scoreboard and compares it.
  task automatic awaitGrant(input string tag, input int maxCycles, output int waited);
    int exp;
    waited = 0;
    while (!grantValid && waited < maxCycles) begin
      @(negedge clk);
      waited++;
    end
    if (!grantValid) begin
      checkOutput({tag, "Timeout"}, 32'd0, 32'd1);
    end else if (expIds.size() == 0) begin
      checkOutput({tag, "Unexpected"}, 32'(grantId), 32'hFFFF_FFFF);
    end else begin
      exp = expIds.pop_front();
      checkOutput({tag, "Id"}, 32'(grantId), 32'(exp));
      checkOutput({tag, "OneHot"}, grantOneHot, 32'd1 << exp);
    end
  endtask

  task automatic ackGrant();
    grantAck = 1'b1;
    @(negedge clk);
    grantAck = 1'b0;
  endtask

  task automatic resetDut();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expIds.delete();
  endtask

  initial begin
    int    waited;
    logic  sawGrant;
    logic  stable;

    reset    = 1'b1;
    grantAck = 1'b0;
    applyStimulus(32'h0, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    checkOutput("rstValid", 32'(grantValid), 32'd0);
    checkOutput("rstId", 32'(grantId), 32'd0);
    checkOutput("rstOneHot", grantOneHot, 32'd0);
    checkOutput("rstPending", pendingOut, 32'd0);
    reset = 1'b0;

    // Single request and its latency
    @(negedge clk);
    applyStimulus(32'h0000_0004, 32'hFFFF_FFFF);
    expIds.push_back(2);
    @(negedge clk);
    checkOutput("latEdge1", 32'(grantValid), 32'd0);
    checkOutput("pendSet", pendingOut, 32'h0000_0004);
    @(negedge clk);
    checkOutput("latEdge2", 32'(grantValid), 32'd0);
    @(negedge clk);
    checkOutput("latEdge3", 32'(grantValid), 32'd1);
    awaitGrant("single", 0, waited);
    ackGrant();
    checkOutput("singlePendClr", pendingOut, 32'd0);
    checkOutput("singleValidClr", 32'(grantValid), 32'd0);
    checkOutput("singleOneHotClr", grantOneHot, 32'd0);
    applyStimulus(32'h0, 32'hFFFF_FFFF);

    // Round robin from reset: 0, 5, 31 then 0, 31
    resetDut();
    applyStimulus(32'h8000_0021, 32'hFFFF_FFFF);
    expIds.push_back(0); expIds.push_back(5); expIds.push_back(31);
    awaitGrant("rr0", 10, waited);
    ackGrant();
    awaitGrant("rr5", 10, waited);
    checkOutput("rrSpacing", 32'(waited), 32'd2);
    ackGrant();
    awaitGrant("rr31", 10, waited);
    ackGrant();
    applyStimulus(32'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    applyStimulus(32'h8000_0001, 32'hFFFF_FFFF);
    expIds.push_back(0); expIds.push_back(31);
    awaitGrant("rrAgain0", 10, waited);
    ackGrant();
    awaitGrant("rrAgain31", 10, waited);
    ackGrant();

    // Wrap from lastId 31
    applyStimulus(32'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    applyStimulus(32'h4000_0008, 32'hFFFF_FFFF);
    expIds.push_back(3); expIds.push_back(30);
    awaitGrant("wrap3", 10, waited);
    ackGrant();
    awaitGrant("wrap30", 10, waited);
    ackGrant();

    // Masked request stays pending; stray acks in IDLE are ignored
    applyStimulus(32'h0, ~32'h0000_0080);
    @(negedge clk);
    applyStimulus(32'h0000_0080, ~32'h0000_0080);
    sawGrant = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      sawGrant = sawGrant | grantValid;
      grantAck = (i % 5 == 0);
    end
    grantAck = 1'b0;
    checkOutput("maskNoGrant", 32'(sawGrant), 32'd0);
    checkOutput("maskPending", pendingOut & 32'h0000_0080, 32'h0000_0080);
    applyStimulus(32'h0000_0080, 32'hFFFF_FFFF);
    expIds.push_back(7);
    awaitGrant("unmask7", 3, waited);
    ackGrant();

    // Stability while mask toggles, then set-wins on the ack cycle
    applyStimulus(32'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    applyStimulus(32'h0000_0200, 32'hFFFF_FFFF);
    expIds.push_back(9);
    awaitGrant("hold9", 10, waited);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      stable = stable & grantValid & (grantId == 5'd9) & (grantOneHot == 32'h0000_0200);
      maskIn = $urandom;
      if (i == 5) reqIn = 32'h0;
    end
    checkOutput("holdStable", 32'(stable), 32'd1);
    applyStimulus(32'h0000_0200, 32'hFFFF_FFFF);
    grantAck = 1'b1;
    @(negedge clk);
    grantAck = 1'b0;
    checkOutput("setWinsPend", pendingOut & 32'h0000_0200, 32'h0000_0200);
    checkOutput("setWinsValid", 32'(grantValid), 32'd0);
    expIds.push_back(9);
    awaitGrant("rearm9", 10, waited);
    ackGrant();

    // Asynchronous reset in GRANT, with requests held through release
    applyStimulus(32'h0, 32'hFFFF_FFFF);
    @(negedge clk);
    applyStimulus(32'h0010_1000, 32'hFFFF_FFFF);
    expIds.push_back(12);
    awaitGrant("preRst12", 10, waited);
    #2 reset = 1'b1;
    #1;
    checkOutput("midRstValid", 32'(grantValid), 32'd0);
    checkOutput("midRstPending", pendingOut, 32'd0);
    checkOutput("midRstOneHot", grantOneHot, 32'd0);
    expIds.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("heldEdges", pendingOut, 32'h0010_1000);
    expIds.push_back(12); expIds.push_back(20);
    awaitGrant("post12", 10, waited);
    ackGrant();
    awaitGrant("post20", 10, waited);
    ackGrant();
    checkOutput("queueEmpty", 32'(expIds.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
